// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and defaults for the pipelined FP add/sub unit.
// Holds the default widths/latency, the float layout and the status encoding.
package fpu_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int MANT_W_DEF = 23;
  localparam int STAGES_DEF = 4;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;

  typedef enum logic [1:0] {
    RS_NORMAL = 2'b00,
    RS_OVF    = 2'b01,
    RS_UNF    = 2'b10,
    RS_NAN    = 2'b11
  } res_state_e;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_INF  = 2'b01,
    SP_NAN  = 2'b10
  } special_e;

endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round: LZC, normalising shift, rounding and exception select.
// In: sum_i/exp_i/sign_i/spec_i; out: packed result_o and state_o.
// Macro FP_ADDSUB_RNE_EN selects round-to-nearest-even, else truncation.
module fp_norm_round
  import fpu_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic [MANT_W+4:0]     sum_i,
  input  logic [EXP_W-1:0]      exp_i,
  input  logic                  sign_i,
  input  logic [1:0]            spec_i,
  output logic [EXP_W+MANT_W:0] result_o,
  output logic [1:0]            state_o
);

  localparam int SW = MANT_W + 5;
  localparam int LW = $clog2(SW + 1);
  localparam int XW = (EXP_W > LW ? EXP_W : LW) + 2;
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ZERO_X = '0;

  logic [LW-1:0]          lz;
  logic [SW-1:0]          norm;
  logic [MANT_W-1:0]      frac;
  logic                   inc;
  logic [MANT_W:0]        frac_r;
  logic signed [XW-1:0]   e_n;
  logic signed [XW-1:0]   e_f;

  always_comb begin
    lz = LW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum_i[i]) lz = LW'(SW - 1 - i);
    end
  end

  // Bit SW-1 is the carry position, so the exponent gains one before lz.
  assign norm = sum_i << lz;
  assign frac = norm[SW-2:4];
  assign e_n  = $signed(XW'(exp_i) + XW'(1) - XW'(lz));

`ifdef FP_ADDSUB_RNE_EN
  logic g, r, s;
  assign g   = norm[3];
  assign r   = norm[2];
  assign s   = |norm[1:0];
  assign inc = g & (r | s | frac[0]);
`else
  logic unused_grs;
  assign unused_grs = ^norm[3:0];
  assign inc = 1'b0;
`endif

  // All-ones + 1 wraps the fraction to zero; the carry bumps the exponent.
  assign frac_r = {1'b0, frac} + (MANT_W+1)'(inc);
  assign e_f    = e_n + XW'(frac_r[MANT_W]);

  always_comb begin
    result_o = {sign_i, e_f[EXP_W-1:0], frac_r[MANT_W-1:0]};
    state_o  = RS_NORMAL;
    if (spec_i == SP_NAN) begin
      result_o = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
      state_o  = RS_NAN;
    end else if (spec_i == SP_INF) begin
      result_o = {sign_i, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (sum_i == '0) begin
      result_o = {sign_i, {(EXP_W+MANT_W){1'b0}}};
    end else if (e_f >= EMAX) begin
      result_o = {sign_i, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      state_o  = RS_OVF;
    end else if (e_f <= ZERO_X) begin
      result_o = {sign_i, {(EXP_W+MANT_W){1'b0}}};
      state_o  = RS_UNF;
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: fully pipelined FP add/sub, latency STAGES (3..8).
// Ports: clk, rst, a, b, op, arg_vld -> result, res_vld, res_state.
// Macro FP_ADDSUB_RNE_EN enables round-to-nearest-even (else truncate).
module fp_addsub_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EXP_W+MANT_W:0] a,
  input  logic [EXP_W+MANT_W:0] b,
  input  logic                  op,
  input  logic                  arg_vld,
  output logic [EXP_W+MANT_W:0] result,
  output logic                  res_vld,
  output logic [1:0]            res_state
);

  localparam int W   = 1 + EXP_W + MANT_W;
  localparam int GW  = MANT_W + 4;
  localparam int SW  = MANT_W + 5;
  localparam int DEP = STAGES - 2;

  // Step 1: unpack, flush subnormals, order by magnitude, align.
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic             a_inf, b_inf, a_nan, b_nan;
  logic [W-2:0]     mag_a, mag_b, x_mag, y_mag;
  logic             swap, x_s;
  logic [GW-1:0]    x_sig, y_full, y_al, lost;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ op;
  assign ea = a[W-2:MANT_W];
  assign eb = b[W-2:MANT_W];

  assign a_inf = (&ea) & ~(|a[MANT_W-1:0]);
  assign b_inf = (&eb) & ~(|b[MANT_W-1:0]);
  assign a_nan = (&ea) & (|a[MANT_W-1:0]);
  assign b_nan = (&eb) & (|b[MANT_W-1:0]);

  assign mag_a = (ea == '0) ? '0 : a[W-2:0];
  assign mag_b = (eb == '0) ? '0 : b[W-2:0];
  assign swap  = mag_b > mag_a;
  assign x_mag = swap ? mag_b : mag_a;
  assign y_mag = swap ? mag_a : mag_b;
  assign x_s   = swap ? sb : sa;

  assign ex     = x_mag[W-2:MANT_W];
  assign ey     = y_mag[W-2:MANT_W];
  assign d      = ex - ey;
  assign x_sig  = {|ex, x_mag[MANT_W-1:0], 3'b000};
  assign y_full = {|ey, y_mag[MANT_W-1:0], 3'b000};

  always_comb begin
    lost = '0;
    if (int'(d) > MANT_W + 3) begin
      y_al = {{(GW-1){1'b0}}, |y_full};
    end else begin
      y_al    = y_full >> d;
      lost    = y_full & ((GW'(1) << d) - GW'(1));
      y_al[0] = y_al[0] | (|lost);
    end
  end

  logic [1:0] sp_d;
  logic       sx_d;

  always_comb begin
    sp_d = SP_NONE;
    sx_d = x_s;
    if (a_nan | b_nan | (a_inf & b_inf & (sa != sb))) begin
      sp_d = SP_NAN;
    end else if (a_inf | b_inf) begin
      sp_d = SP_INF;
      sx_d = a_inf ? sa : sb;
    end
  end

  logic             s1_sx_q, s1_sub_q;
  logic [EXP_W-1:0] s1_ex_q;
  logic [GW-1:0]    s1_mx_q, s1_my_q;
  logic [1:0]       s1_sp_q;

  always_ff @(posedge clk) begin
    s1_sx_q  <= sx_d;
    s1_sub_q <= sa ^ sb;
    s1_ex_q  <= ex;
    s1_mx_q  <= x_sig;
    s1_my_q  <= y_al;
    s1_sp_q  <= sp_d;
  end

  // Step 2: magnitude add/subtract; exact cancellation gives +0.
  logic [SW-1:0] sum_d;
  logic          sign2_d;

  assign sum_d = s1_sub_q ? ({1'b0, s1_mx_q} - {1'b0, s1_my_q})
                          : ({1'b0, s1_mx_q} + {1'b0, s1_my_q});
  assign sign2_d = (s1_sp_q == SP_NONE && s1_sub_q && sum_d == '0)
                   ? 1'b0 : s1_sx_q;

  logic [SW-1:0]    s2_sum_q;
  logic             s2_sign_q;
  logic [EXP_W-1:0] s2_ex_q;
  logic [1:0]       s2_sp_q;

  always_ff @(posedge clk) begin
    s2_sum_q  <= sum_d;
    s2_sign_q <= sign2_d;
    s2_ex_q   <= s1_ex_q;
    s2_sp_q   <= s1_sp_q;
  end

  // Step 3 plus trailing delay registers.
  logic [W-1:0] nr_res;
  logic [1:0]   nr_st;

  fp_norm_round #(
    .EXP_W  (EXP_W),
    .MANT_W (MANT_W)
  ) u_norm (
    .sum_i    (s2_sum_q),
    .exp_i    (s2_ex_q),
    .sign_i   (s2_sign_q),
    .spec_i   (s2_sp_q),
    .result_o (nr_res),
    .state_o  (nr_st)
  );

  logic [STAGES-1:0] vld_q;
  logic [W+1:0]      pipe_q [DEP];
  logic [W+1:0]      pipe_d [DEP];

  always_comb begin
    pipe_d[0] = {nr_res, nr_st};
    for (int i = 1; i < DEP; i++) pipe_d[i] = pipe_q[i-1];
  end

  // The last register only loads on valid, so outputs hold between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEP; i++) pipe_q[i] <= '0;
    end else begin
      vld_q <= {vld_q[STAGES-2:0], arg_vld};
      for (int i = 0; i < DEP; i++) begin
        if (i < DEP - 1 || vld_q[STAGES-2]) pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign result    = pipe_q[DEP-1][W+1:2];
  assign res_state = pipe_q[DEP-1][1:0];
  assign res_vld   = vld_q[STAGES-1];

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed checks of fp_addsub_pipe (binary32, 4 stages).
// Expected values are hand-derived IEEE-754 single-precision results.
module tb_fp_addsub_pipe;

  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, result;
  logic        op, arg_vld, res_vld;
  logic [1:0]  res_state;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] B2B_A [10] = '{32'h3F800000, 32'h40000000, 32'h3FC00000,
                              32'h3F800000, 32'hBF800000, 32'h00000000,
                              32'h40A00000, 32'h7F800000, 32'h3F800000,
                              32'h3F400000};
  logic [31:0] B2B_B [10] = '{32'h3F800000, 32'h3F800000, 32'h40100000,
                              32'h40000000, 32'hBF800000, 32'h40400000,
                              32'h3F000000, 32'h3F800000, 32'hBF800000,
                              32'h3E800000};
  logic        B2B_OP [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] B2B_R [10] = '{32'h40000000, 32'h3F800000, 32'h40700000,
                              32'hBF800000, 32'hC0000000, 32'h40400000,
                              32'h40900000, 32'h7F800000, 32'h40000000,
                              32'h3F800000};

  always #5 clk = ~clk;

  fp_addsub_pipe #(
    .EXP_W  (8),
    .MANT_W (23),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .arg_vld   (arg_vld),
    .result    (result),
    .res_vld   (res_vld),
    .res_state (res_state)
  );

  task automatic single_op(input logic [31:0] va, input logic [31:0] vb,
                           input logic vop, input logic [31:0] er,
                           input logic [1:0] es, input string nm);
    int lat = 0;
    a = va;
    b = vb;
    op = vop;
    arg_vld = 1'b1;
    for (int k = 1; k <= STAGES + 3 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      arg_vld = 1'b0;
      if (res_vld === 1'b1) lat = k;
    end
    vectors++;
    if (lat !== STAGES) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, STAGES);
    end
    vectors++;
    if (result !== er) begin
      miscompares++;
      $display("FAIL %s result: got %h want %h", nm, result, er);
    end
    vectors++;
    if (res_state !== es) begin
      miscompares++;
      $display("FAIL %s state: got %b want %b", nm, res_state, es);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (res_vld !== 1'b0 || result !== er || res_state !== es) begin
      miscompares++;
      $display("FAIL %s hold: got vld=%b %h/%b want vld=0 %h/%b",
               nm, res_vld, result, res_state, er, es);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    arg_vld = 1'b1;
    a = 32'h3F800000;
    b = 32'h3F800000;
    op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    arg_vld = 1'b0;
    vectors++;
    if (res_vld !== 1'b0 || result !== 32'h0 || res_state !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_state: got vld=%b %h/%b want vld=0 0/00",
               res_vld, result, res_state);
    end
    for (int k = 0; k < STAGES + 1; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (res_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ignore cycle %0d: got vld=%b want 0", k, res_vld);
      end
    end
  endtask

  task automatic test_add();
    single_op(32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 2'b00, "add");
  endtask

  task automatic test_sub_exc();
    single_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b00,
              "x_minus_x");
    single_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b01,
              "overflow");
  endtask

  task automatic test_invalid_underflow();
    single_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2'b11,
              "inf_minus_inf");
    single_op(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 2'b10,
              "underflow");
    single_op(32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b11,
              "nan_input");
  endtask

  task automatic test_round();
`ifdef FP_ADDSUB_RNE_EN
    single_op(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 2'b00,
              "round");
`else
    single_op(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 2'b00,
              "round");
`endif
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          a = B2B_A[i];
          b = B2B_B[i];
          op = B2B_OP[i];
          arg_vld = 1'b1;
          @(posedge clk);
          #1;
        end
        arg_vld = 1'b0;
      end
      begin
        int   idx = 0;
        logic exp_v;
        for (int k = 1; k <= STAGES + 14; k++) begin
          @(posedge clk);
          #1;
          exp_v = (k >= STAGES && k < STAGES + 10);
          vectors++;
          if (res_vld !== exp_v) begin
            miscompares++;
            $display("FAIL b2b_vld cycle %0d: got %b want %b",
                     k, res_vld, exp_v);
          end
          if (res_vld === 1'b1 && idx < 10) begin
            vectors++;
            if (result !== B2B_R[idx] || res_state !== 2'b00) begin
              miscompares++;
              $display("FAIL b2b_%0d: got %h/%b want %h/00",
                       idx, result, res_state, B2B_R[idx]);
            end
            idx++;
          end
        end
      end
    join
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 3; i++) begin
      a = 32'h3F800000;
      b = 32'h3F800000;
      op = 1'b0;
      arg_vld = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (res_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_issue %0d: got vld=%b want 0", i, res_vld);
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    arg_vld = 1'b0;
    vectors++;
    if (res_vld !== 1'b0 || result !== 32'h0 || res_state !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_reset: got vld=%b %h/%b want vld=0 0/00",
               res_vld, result, res_state);
    end
    for (int k = 0; k < STAGES + 2; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (res_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_drain cycle %0d: got vld=%b want 0", k, res_vld);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    arg_vld = 1'b0;
    a = '0;
    b = '0;
    op = 1'b0;
    test_reset();
    test_add();
    test_sub_exc();
    test_invalid_underflow();
    test_round();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
